aes128_encrypt_core: RTL
========================

AES128_ENCRYPT_CORE -- requirements
Module: aes128_encrypt_core

Interface
REQ-001 SHALL have parameter EXTERNAL_SBOX, default 0, meaning 1 = byte substitution via sbox_sub_o/sbox_sub_i, 0 = internal combinational S-box (sbox_sub_i ignored).
REQ-002 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n_i  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port data_i  input  128  plaintext, big-endian (AES byte 0 in [127:120]).
REQ-005 SHALL have port start_i  input  1  start request, sampled in IDLE only.
REQ-006 SHALL have port key_start_o  output  1  one-cycle pulse loading the cipher key into the key-expansion stage.
REQ-007 SHALL have port key_req_o  output  1  one-cycle pulse requesting the next round key.
REQ-008 SHALL have port round_key_i  input  128  current round key, internal byte order (AES byte k in [8k+7:8k]).
REQ-009 SHALL have port key_valid_i  input  1  round_key_i valid.
REQ-010 SHALL have port data_o  output  128  ciphertext, big-endian.
REQ-011 SHALL have port valid_o  output  1  data_o valid.
REQ-012 SHALL have port busy_o  output  1  high in every state except IDLE.
REQ-013 SHALL have port sbox_sub_o  output  8  byte to substitute.
REQ-014 SHALL have port sbox_sub_i  input  8  substituted byte, combinational same-cycle return.

Function
REQ-015 SHALL hold a 128-bit state register in internal byte order; load = byte-reverse of data_i; data_o = byte-reverse of state.
REQ-016 SHALL implement FSM states IDLE, INIT, ARK, SUB, SHIFT, MIX, DONE, plus a 4-bit round counter 0..10.
REQ-017 IDLE: start_i=1 -> load state, clear valid_o, round=0, go INIT; otherwise stay.
REQ-018 INIT: key_start_o=1 for exactly this cycle, go ARK.
REQ-019 ARK: key_valid_i=0 -> stall; key_valid_i=1 -> state ^= round_key_i; then round=10 -> DONE, else key_req_o=1 this cycle, round+1, go SUB.
REQ-020 SUB: 16 cycles, byte index 0..15; sbox_sub_o = state byte[index]; byte[index] <= substituted value same cycle; after index 15 go SHIFT.
REQ-021 SHIFT: one cycle, AES ShiftRows (row r rotated left by r columns, byte k = row k%4, column k/4); then round<10 -> MIX, round=10 -> ARK.
REQ-022 MIX: one cycle, AES MixColumns over GF(2^8), reduction polynomial 0x11B; go ARK.
REQ-023 DONE: valid_o <= 1, go IDLE; valid_o and data_o held until next accepted start_i.
REQ-024 SHALL not sample round_key_i earlier than 2 cycles after any key_req_o/key_start_o pulse (guaranteed by FSM sequencing; key_valid_i is stale in those cycles).
REQ-025 Latency with key_valid_i high on every ARK entry: start_i sampled at cycle T -> valid_o high at T+192; exactly 1 key_start_o and 10 key_req_o pulses per operation.
REQ-026 start_i while busy_o=1 SHALL be ignored with no effect on state or outputs.
REQ-027 key_valid_i low for N cycles in ARK SHALL extend latency by exactly N cycles with no other change.
REQ-028 sbox_sub_o SHALL be 8'h00 outside SUB.

Reset
REQ-029 rst_n_i low SHALL immediately force IDLE, round=0, state=0, data_o=0, valid_o=0, busy_o=0, key_start_o=0, key_req_o=0, at any point including mid-operation.
REQ-030 After reset release, no output pulse SHALL occur until a new start_i.

Verification
REQ-031 FIPS-197 C.1: key 000102..0f, data_i 00112233445566778899aabbccddeeff -> data_o 69c4e0d86a7b0430d8cdb78070b4c55a, valid_o at T+192.
REQ-032 FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, data_i 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
REQ-033 Hold key_valid_i low 5 extra cycles on round-3 ARK -> same ciphertext, valid_o at T+197.
REQ-034 Pulse start_i at T+50 during operation -> ignored, result and timing unchanged.
REQ-035 Assert rst_n_i at T+100 -> all outputs 0 immediately; a following C.1 run -> correct ciphertext.
REQ-036 Run both EXTERNAL_SBOX=0 and =1 (bench S-box model) -> identical ciphertext and cycle counts; count 1 key_start_o and 10 key_req_o per run.

Source files
------------

// File: rtl/aes128_encrypt_core.sv
// AES-128 iterative encryption datapath: one byte substitution per cycle,
// round keys supplied by an external key-expansion stage via a start/request handshake.
module aes128_encrypt_core #(
   parameter int EXTERNAL_SBOX = 0
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic [127:0] data_i,
   input  logic         start_i,
   output logic         key_start_o,
   output logic         key_req_o,
   input  logic [127:0] round_key_i,
   input  logic         key_valid_i,
   output logic [127:0] data_o,
   output logic         valid_o,
   output logic         busy_o,
   output logic [7:0]   sbox_sub_o,
   input  logic [7:0]   sbox_sub_i
);

   typedef enum logic [2:0] {IDLE, INIT, ARK, SUB, SHIFT, MIX, DONE} fsm_t;

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   fsm_t          fsm_q, fsm_d;
   logic [3:0]    round_q, round_d;
   logic [3:0]    idx_q, idx_d;
   logic [127:0]  state_q, state_d;
   logic          valid_q, valid_d;

   logic [127:0]  load_w;
   logic [127:0]  shift_w;
   logic [127:0]  mix_w;
   logic [7:0]    cur_byte;
   logic [7:0]    int_sub;
   logic [7:0]    sub_val;

   // External big-endian byte order <-> internal little-endian byte order
   for (genvar gi = 0; gi < 16; gi++) begin : g_swap
      assign load_w[8*gi +: 8]        = data_i[127-8*gi -: 8];
      assign data_o[127-8*gi -: 8]    = state_q[8*gi +: 8];
   end

   // Byte k sits at row k%4, column k/4; row r rotates left by r columns
   for (genvar gi = 0; gi < 16; gi++) begin : g_shift
      localparam int ROW = gi % 4;
      localparam int COL = gi / 4;
      localparam int SRC = ROW + 4 * ((COL + ROW) % 4);
      assign shift_w[8*gi +: 8] = state_q[8*SRC +: 8];
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_mix
      logic [7:0] a0, a1, a2, a3;
      assign a0 = state_q[32*gi +  0 +: 8];
      assign a1 = state_q[32*gi +  8 +: 8];
      assign a2 = state_q[32*gi + 16 +: 8];
      assign a3 = state_q[32*gi + 24 +: 8];
      assign mix_w[32*gi +  0 +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      assign mix_w[32*gi +  8 +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      assign mix_w[32*gi + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      assign mix_w[32*gi + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
   end

   assign cur_byte = state_q[{idx_q, 3'b000} +: 8];
   assign int_sub  = SBOX[cur_byte];
   assign sub_val  = (EXTERNAL_SBOX != 0) ? sbox_sub_i : int_sub;

   assign valid_o = valid_q;
   assign busy_o  = (fsm_q != IDLE);

   always_comb begin
      fsm_d       = fsm_q;
      round_d     = round_q;
      idx_d       = idx_q;
      state_d     = state_q;
      valid_d     = valid_q;
      key_start_o = 1'b0;
      key_req_o   = 1'b0;
      sbox_sub_o  = 8'h00;
      case (fsm_q)
         IDLE: begin
            if (start_i) begin
               state_d = load_w;
               valid_d = 1'b0;
               round_d = 4'd0;
               fsm_d   = INIT;
            end
         end
         INIT: begin
            key_start_o = 1'b1;
            fsm_d       = ARK;
         end
         ARK: begin
            if (key_valid_i) begin
               state_d = state_q ^ round_key_i;
               if (round_q == 4'd10) begin
                  fsm_d = DONE;
               end else begin
                  key_req_o = 1'b1;
                  round_d   = round_q + 4'd1;
                  idx_d     = 4'd0;
                  fsm_d     = SUB;
               end
            end
         end
         SUB: begin
            sbox_sub_o                       = cur_byte;
            state_d[{idx_q, 3'b000} +: 8]    = sub_val;
            idx_d                            = idx_q + 4'd1;
            if (idx_q == 4'd15) fsm_d = SHIFT;
         end
         SHIFT: begin
            state_d = shift_w;
            fsm_d   = (round_q == 4'd10) ? ARK : MIX;
         end
         MIX: begin
            state_d = mix_w;
            fsm_d   = ARK;
         end
         DONE: begin
            valid_d = 1'b1;
            fsm_d   = IDLE;
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         fsm_q   <= IDLE;
         round_q <= 4'd0;
         idx_q   <= 4'd0;
         state_q <= '0;
         valid_q <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         round_q <= round_d;
         idx_q   <= idx_d;
         state_q <= state_d;
         valid_q <= valid_d;
      end
   end

endmodule
